if_id_skid_reg: RTL and testbench

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

---
 rtl/if_id_skid_reg.sv | 119 +++++++++++
 tb/tb_if_id_skid_reg.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer (main + skid) with a registered in_ready.
// Optional saturating stall counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] Instruction_in,
    input  logic [PC_W-1:0]    PC_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] Instruction_out,
    output logic [PC_W-1:0]    PC_out,
    output logic [15:0]        stall_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    logic w_out_valid;
    logic w_accept;
    logic w_deliver;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_deliver   = w_out_valid & out_ready;

    assign in_ready        = r_in_ready;
    assign out_valid       = w_out_valid;
    assign Instruction_out = r_main_instr;
    assign PC_out          = r_main_pc;

    // Main holds NOP/0 whenever the stage is empty, so the outputs come straight from registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // NOTE: data registers are reset too, because main doubles as the bubble output.
            r_state      <= S_EMPTY;
            r_in_ready   <= 1'b1;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main_instr <= Instruction_in;
                        r_main_pc    <= PC_in;
                        r_state      <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_main_instr <= Instruction_in;
                        r_main_pc    <= PC_in;
                    end else if (w_accept) begin
                        r_skid_instr <= Instruction_in;
                        r_skid_pc    <= PC_in;
                        r_in_ready   <= 1'b0;
                        r_state      <= S_TWO;
                    end else if (w_deliver) begin
                        r_main_instr <= NOP_INSTR;
                        r_main_pc    <= '0;
                        r_state      <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a deliver can move the state.
                    if (w_deliver) begin
                        r_main_instr <= r_skid_instr;
                        r_main_pc    <= r_skid_pc;
                        r_in_ready   <= 1'b1;
                        r_state      <= S_ONE;
                    end
                end
                default: begin
                    r_state      <= S_EMPTY;
                    r_in_ready   <= 1'b1;
                    r_main_instr <= NOP_INSTR;
                    r_main_pc    <= '0;
                end
            endcase
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] r_stall_count;

    // Flush does not clear the counter; it counts every cycle ID refuses a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus randomized traffic
// checked against a queue-based model of the two-entry buffer.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] Instruction_in, PC_in;
    logic        in_ready, out_valid;
    logic [31:0] Instruction_out, PC_out;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    beat_t       q[$];
    logic [15:0] m_cnt;

    if_id_skid_reg #(
        .INSTR_W  (32),
        .PC_W     (32),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .Instruction_in (Instruction_in),
        .PC_in          (PC_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Instruction_out(Instruction_out),
        .PC_out         (PC_out),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    wire [81:0] obs = {out_valid, in_ready, Instruction_out, PC_out, stall_count};

    // Expected outputs: the buffer is a FIFO of at most two beats; head is what ID sees.
    function automatic logic [81:0] model_vec();
        if (q.size() > 0)
            return {1'b1, (q.size() < 2), q[0].instr, q[0].pc, m_cnt};
        else
            return {1'b0, 1'b1, NOP, 32'h0, m_cnt};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic rst);
        in_valid       = iv;
        Instruction_in = instr;
        PC_in          = pc;
        out_ready      = ordy;
        flush          = fl;
        reset          = rst;
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then settle.
    task automatic tick();
        bit    can_acc;
        bit    del;
        beat_t b;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_cnt = 16'h0000;
        end else begin
            if (STALL_EN && q.size() > 0 && !out_ready && m_cnt != 16'hFFFF)
                m_cnt = m_cnt + 16'd1;
            if (flush) begin
                q.delete();
            end else begin
                can_acc = (q.size() < 2);
                del     = (q.size() > 0) && out_ready;
                if (del) void'(q.pop_front());
                if (in_valid && can_acc) begin
                    b.instr = Instruction_in;
                    b.pc    = PC_in;
                    q.push_back(b);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 32'h55, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, NOP, 32'h0, 16'h0})
            begin errors++; $display("FAIL reset_values got=%h want=%h", obs, {1'b0, 1'b1, NOP, 32'h0, 16'h0}); end
        checks++;
        if (obs !== model_vec())
            begin errors++; $display("FAIL reset_model got=%h want=%h", obs, model_vec()); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_first_beat();
        do_reset();
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({out_valid, Instruction_out, PC_out} !== {1'b1, 32'hFFFF_FFFF, 32'h1})
            begin errors++; $display("FAIL first_beat got v=%b i=%h pc=%h want v=1 i=ffffffff pc=1",
                                     out_valid, Instruction_out, PC_out); end
        in_valid = 1'b0;
        tick();
        checks++;
        if (obs !== model_vec())
            begin errors++; $display("FAIL first_beat_drain got=%h want=%h", obs, model_vec()); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, $urandom, i, 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (PC_out !== 32'(i) || in_ready !== 1'b1 || out_valid !== 1'b1)
                begin errors++; $display("FAIL stream[%0d] got pc=%h rdy=%b v=%b want pc=%h rdy=1 v=1",
                                         i, PC_out, in_ready, out_valid, i); end
            checks++;
            if (obs !== model_vec())
                begin errors++; $display("FAIL stream_model[%0d] got=%h want=%h", i, obs, model_vec()); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] pcs[3];
        do_reset();
        drive(1'b1, 32'hA1, 32'h1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hA2, 32'h2, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b0 || PC_out !== 32'h1)
            begin errors++; $display("FAIL stall_enter got rdy=%b pc=%h want rdy=0 pc=1", in_ready, PC_out); end
        drive(1'b1, 32'hA3, 32'h3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || PC_out !== 32'h1 || Instruction_out !== 32'hA1)
                begin errors++; $display("FAIL stall_hold[%0d] got rdy=%b pc=%h i=%h want rdy=0 pc=1 i=a1",
                                         i, in_ready, PC_out, Instruction_out); end
        end
        out_ready = 1'b1;
        pcs[0] = PC_out;
        tick();
        pcs[1] = PC_out;
        tick();
        pcs[2] = PC_out;
        in_valid = 1'b0;
        checks++;
        if ({pcs[0], pcs[1], pcs[2]} !== {32'h1, 32'h2, 32'h3})
            begin errors++; $display("FAIL stall_order got %h,%h,%h want 1,2,3", pcs[0], pcs[1], pcs[2]); end
        checks++;
        if (stall_count !== (STALL_EN ? 16'd3 : 16'd0))
            begin errors++; $display("FAIL stall_count got=%0d want=%0d", stall_count, STALL_EN ? 3 : 0); end
        tick();
        checks++;
        if (obs !== model_vec())
            begin errors++; $display("FAIL stall_drain got=%h want=%h", obs, model_vec()); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'hB7, 32'h7, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB8, 32'h8, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB9, 32'h9, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if ({out_valid, Instruction_out, PC_out, in_ready} !== {1'b0, NOP, 32'h0, 1'b1})
            begin errors++; $display("FAIL flush got v=%b i=%h pc=%h rdy=%b want v=0 i=%h pc=0 rdy=1",
                                     out_valid, Instruction_out, PC_out, in_ready, NOP); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC_out === 32'h9 || out_valid !== 1'b0)
                begin errors++; $display("FAIL flush_ghost[%0d] got v=%b pc=%h want v=0 pc!=9",
                                         i, out_valid, PC_out); end
        end
        checks++;
        if (obs !== model_vec())
            begin errors++; $display("FAIL flush_model got=%h want=%h", obs, model_vec()); end
    endtask

    task automatic test_reset_flush();
        do_reset();
        drive(1'b1, 32'hC1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC2, 32'h12, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (stall_count !== (STALL_EN ? 16'd5 : 16'd0) || in_ready !== 1'b0)
            begin errors++; $display("FAIL pre_reset got cnt=%0d rdy=%b want cnt=%0d rdy=0",
                                     stall_count, in_ready, STALL_EN ? 5 : 0); end
        drive(1'b1, 32'hC3, 32'h13, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, NOP, 32'h0, 16'h0})
            begin errors++; $display("FAIL reset_flush got=%h want=%h", obs, {1'b0, 1'b1, NOP, 32'h0, 16'h0}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                if (bad++ < 10) $display("FAIL random[%0d] got=%h want=%h", i, obs, model_vec());
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        int n;
        n = STALL_EN ? 65540 : 40;
        do_reset();
        drive(1'b1, 32'hD1, 32'h21, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
        checks++;
        if (stall_count !== (STALL_EN ? 16'hFFFF : 16'h0000))
            begin errors++; $display("FAIL saturate got=%h want=%h", stall_count, STALL_EN ? 16'hFFFF : 16'h0); end
        checks++;
        if (obs !== model_vec())
            begin errors++; $display("FAIL saturate_model got=%h want=%h", obs, model_vec()); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_count !== (STALL_EN ? 16'hFFFF : 16'h0000) || out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_keeps_count got cnt=%h v=%b want cnt=%h v=0",
                                     stall_count, out_valid, STALL_EN ? 16'hFFFF : 16'h0); end
    endtask

    initial begin
        m_cnt = 16'h0000;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        test_reset();
        test_first_beat();
        test_stream();
        test_stall();
        test_flush();
        test_reset_flush();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
